// File: rtl/pmips_io_pkg.sv
// Shared constants for the PMIPS MEM-stage data port: IO map, word width and
// the 7-segment hex lookup.
package pmips_io_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEG_W  = 7;

  localparam logic [11:0]       IO_BASE   = 12'hFFF;
  localparam logic [WORD_W-1:0] ADDR_SW0  = 16'hFFF0;
  localparam logic [WORD_W-1:0] ADDR_SW1  = 16'hFFF2;
  localparam logic [WORD_W-1:0] ADDR_DISP = 16'hFFF8;

  // Entry n is the active-high segment pattern (bit0=a .. bit6=g) for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/data_memory_io_sevenseg_decoder.sv
// Combinational hex-digit to 7-segment pattern decoder.
module sevenseg_decoder
  import pmips_io_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = seg_decode(hex);

endmodule

// File: rtl/data_memory_io.sv
// PMIPS data memory with memory-mapped switches and a 7-segment display register.
// Define SEVENSEG_DECODE_EN to store hex-decoded display patterns instead of raw bits.
module data_memory_io
  import pmips_io_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [WORD_W-1:0] rdata,
  output logic [SEG_W-1:0]  io_display,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              write,
  input  logic              read,
  input  logic              io_sw0,
  input  logic              io_sw1
);

  logic              is_io_c;
  logic [AW-1:0]     ram_idx_c;
  logic              ram_we_c;
  logic [SEG_W-1:0]  disp_wval_c;
  logic [SEG_W-1:0]  disp_d;
  logic [SEG_W-1:0]  disp_q;
  logic              wdata_unused_c;
  logic [WORD_W-1:0] mem_q [DEPTH];

  // Byte address to word index; upper bits alias by design.
  assign is_io_c   = (addr[15:4] == IO_BASE);
  assign ram_idx_c = addr[AW:1];
  assign ram_we_c  = write && !is_io_c;

`ifdef SEVENSEG_DECODE_EN
  sevenseg_decoder u_sevenseg_decoder (
    .hex   (wdata[3:0]),
    .seg_c (disp_wval_c)
  );
  assign wdata_unused_c = ^wdata[WORD_W-1:4];
`else
  assign disp_wval_c    = wdata[SEG_W-1:0];
  assign wdata_unused_c = ^wdata[WORD_W-1:SEG_W];
`endif

  // RAM is never cleared, so its write port ignores reset.
  always_ff @(posedge clock) begin
    if (ram_we_c) begin
      mem_q[ram_idx_c] <= wdata;
    end
  end

  always_comb begin
    disp_d = disp_q;
    if (write && (addr == ADDR_DISP)) begin
      disp_d = disp_wval_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign io_display = disp_q;

  // Combinational read path; old contents remain visible until the write edge.
  always_comb begin
    rdata = '0;
    if (read) begin
      if (is_io_c) begin
        case (addr)
          ADDR_SW0:  rdata = WORD_W'(io_sw0);
          ADDR_SW1:  rdata = WORD_W'(io_sw1);
          ADDR_DISP: rdata = WORD_W'(disp_q);
          default:   rdata = '0;
        endcase
      end else begin
        rdata = mem_q[ram_idx_c];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_io.sv
// Self-checking bench for data_memory_io: directed vectors plus a per-cycle
// comparison against a word-array / display-register model.
module tb_data_memory_io;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rdata;
  logic [6:0]  io_display;
  logic [15:0] addr  = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        write = 1'b0;
  logic        read  = 1'b0;
  logic        io_sw0 = 1'b0;
  logic        io_sw1 = 1'b0;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

`ifdef SEVENSEG_DECODE_EN
  localparam logic [6:0] EXP_5  = 7'h6D;
  localparam logic [6:0] EXP_AB = 7'h7C;
`else
  localparam logic [6:0] EXP_5  = 7'h05;
  localparam logic [6:0] EXP_AB = 7'h2B;
`endif

  data_memory_io dut (
    .clock      (clock),
    .reset      (reset),
    .rdata      (rdata),
    .io_display (io_display),
    .addr       (addr),
    .wdata      (wdata),
    .write      (write),
    .read       (read),
    .io_sw0     (io_sw0),
    .io_sw1     (io_sw1)
  );

  always #5 clock = ~clock;

  // Behavioural model: 128-word array with known-flags, plus display register.
  logic [15:0] m_mem [128];
  bit          m_val [128];
  logic [6:0]  m_disp;
  logic [6:0]  hex_tab [16];

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 128; i++) m_val[i] = 1'b0;
  end

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) / 2) % 128;
  endfunction

  function automatic logic [6:0] disp_val(input logic [15:0] d);
`ifdef SEVENSEG_DECODE_EN
    return hex_tab[d % 16];
`else
    return 7'(d % 128);
`endif
  endfunction

  always @(posedge clock) begin
    if (write && (addr < 16'hFFF0)) begin
      m_mem[word_of(addr)] <= wdata;
      m_val[word_of(addr)] <= 1'b1;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) m_disp <= 7'h00;
    else if (write && addr == 16'hFFF8) m_disp <= disp_val(wdata);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (checking) begin
      chk("model_display", {9'b0, io_display}, {9'b0, m_disp});
      if (!read) chk("model_rdata_idle", rdata, 16'h0000);
      else if (addr == 16'hFFF0) chk("model_sw0", rdata, {15'b0, io_sw0});
      else if (addr == 16'hFFF2) chk("model_sw1", rdata, {15'b0, io_sw1});
      else if (addr == 16'hFFF8) chk("model_disp_rd", rdata, {9'b0, m_disp});
      else if (addr >= 16'hFFF0) chk("model_io_other", rdata, 16'h0000);
      else if (m_val[word_of(addr)]) chk("model_ram", rdata, m_mem[word_of(addr)]);
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
    addr = a; wdata = d; write = w; read = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    tick;
    chk("reset_display", {9'b0, io_display}, 16'h0000);
    chk("reset_rdata", rdata, 16'h0000);
    tick;
    reset = 1'b0;
    checking = 1'b1;

    // Display write and readback.
    drive(16'hFFF8, 16'h0005, 1'b1, 1'b0);
    tick;
    chk("disp_after_write", {9'b0, io_display}, {9'b0, EXP_5});
    drive(16'hFFF8, 16'h0000, 1'b0, 1'b1);
    chk("disp_readback", rdata, {9'b0, EXP_5});

    // Asynchronous reset mid-cycle.
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 chk("async_reset_display", {9'b0, io_display}, 16'h0000);
    tick;
    reset = 1'b0;

    // RAM round trip and aliasing.
    drive(16'h0010, 16'hBEEF, 1'b1, 1'b0);
    tick;
    drive(16'h0010, 16'h0000, 1'b0, 1'b1);
    chk("ram_read", rdata, 16'hBEEF);
    drive(16'h0011, 16'h0000, 1'b0, 1'b1);
    chk("ram_byte_ignored", rdata, 16'hBEEF);
    drive(16'h0110, 16'h0000, 1'b0, 1'b1);
    chk("ram_alias", rdata, 16'hBEEF);
    drive(16'h0010, 16'h0000, 1'b0, 1'b0);
    chk("read_gated", rdata, 16'h0000);
    tick;

    // Switches.
    io_sw0 = 1'b1; io_sw1 = 1'b0;
    drive(16'hFFF0, 16'h0000, 1'b0, 1'b1);
    chk("sw0_read", rdata, 16'h0001);
    drive(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    chk("sw1_read_low", rdata, 16'h0000);
    io_sw1 = 1'b1;
    #1 chk("sw1_same_cycle", rdata, 16'h0001);
    tick;

    // Write to a switch address touches neither RAM alias nor switch readback.
    drive(16'h00F0, 16'h1234, 1'b1, 1'b0);
    tick;
    drive(16'hFFF0, 16'hFFFF, 1'b1, 1'b1);
    chk("sw_write_pre", rdata, 16'h0001);
    tick;
    chk("sw_write_post", rdata, 16'h0001);
    drive(16'h00F0, 16'h0000, 1'b0, 1'b1);
    chk("sw_write_no_ram", rdata, 16'h1234);
    tick;

    // Unmapped IO: reads zero, writes ignored.
    drive(16'hFFF4, 16'h007F, 1'b1, 1'b1);
    chk("io_other_read", rdata, 16'h0000);
    tick;
    chk("io_other_no_disp", {9'b0, io_display}, 16'h0000);

    // Same-cycle read and write.
    drive(16'h0020, 16'h1111, 1'b1, 1'b0);
    tick;
    drive(16'h0020, 16'h2222, 1'b1, 1'b1);
    chk("rw_before_edge", rdata, 16'h1111);
    tick;
    chk("rw_after_edge", rdata, 16'h2222);

    // Second display pattern.
    drive(16'hFFF8, 16'h00AB, 1'b1, 1'b1);
    tick;
    chk("disp_ab", {9'b0, io_display}, {9'b0, EXP_AB});
    chk("disp_ab_readback", rdata, {9'b0, EXP_AB});

    // Assorted RAM patterns, checked per cycle by the model.
    for (int i = 0; i < 8; i++) begin
      drive(16'(i * 6 + 64), 16'hA5A5 ^ 16'(i * 16'h1357), 1'b1, 1'b0);
      tick;
    end
    for (int i = 0; i < 8; i++) begin
      drive(16'(i * 6 + 64), 16'h0000, 1'b0, 1'b1);
      tick;
    end
    drive(16'h0040, 16'h0000, 1'b0, 1'b1);
    chk("ram_pattern0", rdata, 16'hA5A5);

    // Reset with a display write pending: display drops it, RAM still writes.
    drive(16'h0030, 16'h5A5A, 1'b1, 1'b0);
    reset = 1'b1;
    tick;
    drive(16'hFFF8, 16'h0003, 1'b1, 1'b0);
    tick;
    chk("reset_drops_disp", {9'b0, io_display}, 16'h0000);
    reset = 1'b0;
    drive(16'h0030, 16'h0000, 1'b0, 1'b1);
    chk("reset_ram_write", rdata, 16'h5A5A);
    tick;

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
